// File: rtl/ct_stream_ctrl_pkg.sv
// Shared constants for the ciphertext readout path: field degree, code
// length, coefficient packing and the stream/digest geometry.
package ct_stream_ctrl_pkg;

  localparam int CT_M     = 83;
  localparam int CT_N     = 189;
  localparam int CT_DIGIT = 4;

  localparam int BEAT_W   = 32;
  localparam int DIGEST_W = 512;

  // Ceiling log2, never below 1 so derived vectors always have a width.
  function automatic int ct_clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ct_stream_ctrl_shifter.sv
// Load/shift register that emits a wide word as 32-bit beats, low beat
// first, with zero fill above W. Used for ct words and for the digest.
module ct_stream_ctrl_shifter
  import ct_stream_ctrl_pkg::*;
#(
  parameter  int W   = 32,
  localparam int BPW = (W + BEAT_W - 1) / BEAT_W,
  localparam int PW  = BPW * BEAT_W,
  localparam int CW  = ct_clog2(BPW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [W-1:0]  din,
  output logic [31:0]   dout,
  output logic          last
);

  logic [PW-1:0] sh;
  logic [CW-1:0] beat_cnt;

  // Data register: padded to whole beats so the top beat reads zero above W.
  always_ff @(posedge clk) begin
    if (load) begin
      sh <= PW'(din);
    end else if (shift) begin
      sh <= sh >> BEAT_W;
    end
  end

  // Beat counter: restarts on every load, wraps after the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (load) begin
      beat_cnt <= '0;
    end else if (shift) begin
      beat_cnt <= last ? '0 : beat_cnt + CW'(1);
    end
  end

  assign dout = sh[31:0];
  assign last = (beat_cnt == CW'(BPW - 1));

endmodule

// File: rtl/ct_stream_ctrl.sv
// Ciphertext readout sequencer: reads every ct memory word, streams it as
// 32-bit beats, then streams the latched 512-bit digest, low word first.
module ct_stream_ctrl
  import ct_stream_ctrl_pkg::*;
#(
  parameter  int M     = CT_M,
  parameter  int N     = CT_N,
  parameter  int DIGIT = CT_DIGIT,
  localparam int W     = M * DIGIT,
  localparam int DEPTH = (N / DIGIT) + ((N % DIGIT != 0) ? 1 : 0),
  localparam int AW    = ct_clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                start,
  input  logic [DIGEST_W-1:0] digest,
  output logic [AW-1:0]       ct_addr,
  output logic                ct_we,
  input  logic [W-1:0]        ct_dout,
  output logic [31:0]         out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    SEND_CT,
    SEND_HASH,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] word_cnt;
  logic          start_ok;
  logic          final_word;
  logic [31:0]   ct_beat;
  logic          ct_last;
  logic [31:0]   hash_beat;
  logic          hash_last;

  assign start_ok   = (state == IDLE) && start;
  assign final_word = (word_cnt == AW'(DEPTH - 1));
  assign ct_we      = 1'b0;

  ct_stream_ctrl_shifter #(.W(W)) u_ct_sh (
    .clk   (clk),
    .rst   (rst_b),
    .load  (state == RD_WAIT),
    .shift ((state == SEND_CT) && out_ready),
    .din   (ct_dout),
    .dout  (ct_beat),
    .last  (ct_last)
  );

  // The digest is captured by the accepted start and replayed as 16 beats.
  ct_stream_ctrl_shifter #(.W(DIGEST_W)) u_hash_sh (
    .clk   (clk),
    .rst   (rst_b),
    .load  (start_ok),
    .shift ((state == SEND_HASH) && out_ready),
    .din   (digest),
    .dout  (hash_beat),
    .last  (hash_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Word counter: cleared by start, advanced after the last beat of a non-final word.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      word_cnt <= '0;
    end else if (start_ok) begin
      word_cnt <= '0;
    end else if ((state == SEND_CT) && out_ready && ct_last && !final_word) begin
      word_cnt <= word_cnt + AW'(1);
    end
  end

  // Next state and Moore outputs; ct_addr stays 0 outside the read states
  // because the top ORs it with other memory masters.
  always_comb begin
    state_nxt = state;
    ct_addr   = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RD_ISSUE;
      end
      RD_ISSUE: begin
        ct_addr   = word_cnt;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        ct_addr   = word_cnt;
        state_nxt = SEND_CT;
      end
      SEND_CT: begin
        out_valid = 1'b1;
        out_data  = ct_beat;
        if (out_ready && ct_last) state_nxt = final_word ? SEND_HASH : RD_ISSUE;
      end
      SEND_HASH: begin
        out_valid = 1'b1;
        out_data  = hash_beat;
        out_last  = hash_last;
        if (out_ready && hash_last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ct_stream_ctrl.sv
// Directed bench: small configuration (W=40, DEPTH=3, BPW=2) for sequence,
// backpressure, ignored restart and mid-packet reset; default configuration
// for a full-length smoke run.
module tb_ct_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small configuration DUT.
  logic         rst_b;
  logic         start;
  logic [511:0] digest;
  logic [1:0]   ct_addr;
  logic         ct_we;
  logic [39:0]  ct_dout;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         done;
  logic [39:0]  mem [0:3];

  always @(posedge clk) ct_dout <= mem[ct_addr];

  ct_stream_ctrl #(.M(20), .N(5), .DIGIT(2)) u_small (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .digest    (digest),
    .ct_addr   (ct_addr),
    .ct_we     (ct_we),
    .ct_dout   (ct_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Default configuration DUT (W=332, DEPTH=48, BPW=11).
  logic         big_start;
  logic [511:0] big_digest;
  logic [5:0]   big_addr;
  logic         big_we;
  logic [331:0] big_dout;
  logic [31:0]  big_data;
  logic         big_valid;
  logic         big_ready;
  logic         big_last;
  logic         big_busy;
  logic         big_done;
  logic [331:0] big_mem [0:63];

  always @(posedge clk) big_dout <= big_mem[big_addr];

  ct_stream_ctrl u_big (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (big_start),
    .digest    (big_digest),
    .ct_addr   (big_addr),
    .ct_we     (big_we),
    .ct_dout   (big_dout),
    .out_data  (big_data),
    .out_valid (big_valid),
    .out_ready (big_ready),
    .out_last  (big_last),
    .busy      (big_busy),
    .done      (big_done)
  );

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] exp_beat [0:21];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One small-config packet. rnd: random ready; pulse_at: beat index at
  // which a stray start is pulsed; abort_at: beat index at which reset hits.
  task automatic run_small(input bit rnd, input int pulse_at, input int abort_at);
    int          idx;
    int          cyc;
    int          ndone;
    int          lat;
    int          vafter;
    bit          stall;
    bit          pulsed;
    bit          rdy;
    logic [31:0] pdata;
    logic        plast;
    idx = 0; cyc = 0; ndone = 0; lat = -1; vafter = 0;
    stall = 0; pulsed = 0; pdata = '0; plast = 1'b0;
    @(negedge clk);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_addr", 64'(ct_addr), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    start = 1'b1;
    while (idx < 22 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) ndone++;
      if (cyc == 1) chk("busy_after_start", 64'(busy), 64'd1);
      if (out_valid && lat < 0) begin
        lat = cyc;
        chk("start_to_valid", 64'(lat), 64'd3);
      end
      chk("ct_we", 64'(ct_we), 64'd0);
      if (stall) begin
        chk("stall_data", 64'(out_data), 64'(pdata));
        chk("stall_last", 64'(out_last), 64'(plast));
      end
      if (abort_at >= 0 && idx == abort_at && out_valid) begin
        rst_b = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_data", 64'(out_data), 64'd0);
        chk("abort_last", 64'(out_last), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_addr", 64'(ct_addr), 64'd0);
        return;
      end
      if (!pulsed && pulse_at >= 0 && idx == pulse_at) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (out_valid && rdy) begin
        chk("beat", 64'(out_data), 64'(exp_beat[idx]));
        chk("last", 64'(out_last), 64'(idx == 21));
        if (idx >= 6) chk("hash_addr", 64'(ct_addr), 64'd0);
        idx++;
      end
      stall = out_valid && !rdy;
      pdata = out_data;
      plast = out_last;
    end
    if (idx < 22) chk("timeout_beats", 64'(idx), 64'd22);
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("early_done", 64'(ndone), 64'd0);
    @(negedge clk);
    chk("done_clear", 64'(done), 64'd0);
    chk("idle_addr_after", 64'(ct_addr), 64'd0);
    repeat (5) begin
      @(negedge clk);
      ndone += int'(done);
      vafter += int'(out_valid);
    end
    chk("extra_done", 64'(ndone), 64'd0);
    chk("no_restart", 64'(vafter), 64'd0);
  endtask

  // Full-length packet on the default configuration.
  task automatic run_big();
    int          beats;
    int          cyc;
    int          w;
    int          b;
    logic [31:0] e;
    beats = 0; cyc = 0;
    @(negedge clk);
    big_start = 1'b1;
    big_ready = 1'b1;
    while (beats < 544 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      big_start = 1'b0;
      if (big_valid) begin
        if (beats < 528) begin
          w = beats / 11;
          b = beats % 11;
          if (b == 0)       e = ~32'(w);
          else if (b == 10) e = 32'h0000_0FFF;
          else              e = 32'hFFFF_FFFF;
        end else begin
          e = 32'h1000_0000 + 32'(beats - 528);
        end
        chk("big_beat", 64'(big_data), 64'(e));
        chk("big_last", 64'(big_last), 64'(beats == 543));
        beats++;
      end
    end
    chk("big_total", 64'(beats), 64'd544);
    chk("big_we", 64'(big_we), 64'd0);
    @(negedge clk);
    chk("big_done", 64'(big_done), 64'd1);
    chk("big_busy", 64'(big_busy), 64'd0);
  endtask

  initial begin
    rst_b = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    big_start = 1'b0;
    big_ready = 1'b0;
    digest = '0;
    big_digest = '0;
    mem[0] = 40'hAB_1234_5678;
    mem[1] = 40'hCD_9ABC_DEF0;
    mem[2] = 40'h00_0000_0001;
    mem[3] = 40'hEE_EEEE_EEEE;
    for (int i = 0; i < 64; i++) big_mem[i] = {332{1'b1}} ^ 332'(i);
    for (int i = 0; i < 16; i++) begin
      digest[32*i +: 32]     = 32'(i);
      big_digest[32*i +: 32] = 32'h1000_0000 + 32'(i);
    end
    exp_beat[0] = 32'h1234_5678;
    exp_beat[1] = 32'h0000_00AB;
    exp_beat[2] = 32'h9ABC_DEF0;
    exp_beat[3] = 32'h0000_00CD;
    exp_beat[4] = 32'h0000_0001;
    exp_beat[5] = 32'h0000_0000;
    for (int i = 0; i < 16; i++) exp_beat[6+i] = 32'(i);

    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", 64'(ct_addr), 64'd0);
    chk("rst_big_valid", 64'(big_valid), 64'd0);
    rst_b = 1'b0;

    run_small(1'b0, -1, -1);
    run_small(1'b1, -1, -1);
    run_small(1'b0, 4, -1);
    run_small(1'b1, -1, 2);
    run_small(1'b0, -1, -1);
    run_big();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ct_stream_ctrl.md
Name: ct_stream_ctrl

Overview:
Sequences readout of the finished ROLLO-II ciphertext after encryption completes. It owns the read side of the single-port ct memory and the latched SHA3 digest. It serialises both onto a 32-bit valid/ready output stream: first all ct memory words, then the 512-bit digest. It sits between c_Gen_Ctrl's done pulse and the top-level data/ready pins, and lets the host pull ciphertext at its own pace.

Parameters:
M, 83, GF(2^m) extension degree
N, 189, code length (coefficients of ct)
DIGIT, 4, coefficients packed per ct memory word
W, M*DIGIT, ct memory word width (derived)
DEPTH, (N/DIGIT)+((N%DIGIT)!=0), ct memory words (derived)
AW, CLOG2(DEPTH), ct address width (derived)
BPW, (W+31)/32, 32-bit beats per ct word (derived)

Ports:
clk  in  1  system clock
rst_b  in  1  synchronous reset, active-high (rst_b=1 resets)
start  in  1  one-cycle pulse: ciphertext and digest valid (driven by c_Gen_Ctrl done)
digest  in  512  SHA3 output, sampled on accepted start
ct_addr  out  AW  ct memory address; OR-muxed with other masters
ct_we  out  1  ct memory write enable, constant 0
ct_dout  in  W  ct memory read data, 1-cycle synchronous read latency
out_data  out  32  stream data
out_valid  out  1  stream beat valid
out_ready  in  1  consumer ready
out_last  out  1  final beat of the packet, qualified by out_valid
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (rst_b=1 at clk edge): state IDLE; ct_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0; word/beat counters=0. Applies mid-operation; a partially sent packet is abandoned.
- ct_addr must be 0 whenever state is IDLE or SEND_HASH, because the top OR-combines addresses. ct_we is tied 0.
- States: IDLE -> RD_ISSUE -> RD_WAIT -> SEND_CT -> (RD_ISSUE | SEND_HASH) -> DONE -> IDLE.
- IDLE: on start, latch digest into hash_q, set word_cnt=0, busy=1, go to RD_ISSUE. start while busy is ignored.
- RD_ISSUE: drive ct_addr=word_cnt, go to RD_WAIT.
- RD_WAIT: hold ct_addr. Next edge, load ct_dout into shift register sh (W bits), set beat_cnt=0, go to SEND_CT.
- SEND_CT: out_valid=1, out_data=sh[31:0]. Bits above W in the last beat of a word read 0.
  - On a handshake (out_valid&out_ready): sh>>=32, beat_cnt++.
  - At beat_cnt==BPW-1 with a handshake: if word_cnt==DEPTH-1, go to SEND_HASH with hbeat=0; else word_cnt++ and go to RD_ISSUE.
  - out_valid drops for 2 cycles between ct words (read latency bubble).
- SEND_HASH: out_valid=1, out_data=hash_q[32*hbeat+:32], low word first. 16 beats. out_last=1 when hbeat==15.
  - Handshake on the last beat: go to DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- Backpressure: while out_valid&!out_ready, out_data and out_last stay stable; no counter advances.
- Padding coefficients in the final ct word (beyond N) are sent as stored; the block does not mask them.
- Total beats per packet = DEPTH*BPW+16. A start accepted in the same cycle as done is impossible (IDLE is entered after DONE).
- Minimum latency: start to first out_valid = 3 cycles.

Decomposition:
- Shared define/package: M, N, DIGIT, derived DEPTH, AW, BPW, and the CLOG2 macro. These are already global.
- State encoding localparams stay local.
- One natural sub-module: stream_shifter. It is a W-bit load/shift register with a beat counter, emitting 32-bit slices with zero fill. It can be reused for the digest path with W=512.

Test Plan:
- Small config M=20, DIGIT=2, N=5 (W=40, DEPTH=3, BPW=2). ct = {40'hAB_1234_5678, 40'hCD_9ABC_DEF0, 40'h00_0000_0001}, digest = 512'h{0x0..0xF words}, out_ready=1 constantly -> beats 12345678, 000000AB, 9ABCDEF0, 000000CD, 00000001, 00000000, then 00000000..0000000F. out_last on beat 22 only; done exactly 1 cycle after.
- Random out_ready (50%) on the same data -> identical 22-beat sequence; out_data stable while stalled.
- start pulsed again at beat 5 -> ignored; the sequence is unchanged and only 1 done occurs.
- rst_b asserted during SEND_CT beat 3 -> next cycle all outputs 0 and ct_addr=0. A following start replays from beat 1.
- Check ct_addr==0 in IDLE and SEND_HASH, ct_we==0 always, and start-to-first-valid == 3 cycles.
- Default config (W=332, DEPTH=48) smoke test -> 544 beats total; the 11th beat of each word has bits [31:12]=0.
